binary_morph: RTL and testbench

Streaming 3x3 morphological post-filter that sits directly downstream of the adaptive binarization stage. On a start pulse it scans the 256x256 binary result map by driving `pixel_address` into the binarization stage and sampling `bin_data`. It applies erode, dilate, majority denoise or pass-through over a 3x3 window built from two line buffers. It emits one filtered pixel per cycle in raster order for the next stage, or for a writer into output RAM.

---
 rtl/img_pkg.sv | 34 +++
 rtl/morph_window3x3.sv | 97 +++++++++
 rtl/binary_morph.sv | 132 +++++++++++++
 tb/tb_binary_morph.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image geometry, morphology mode codes, stream timing and the 3x3 kernel
// function used by the binarization post-filter.
package img_pkg;
    localparam int IMG_WIDTH  = 256;
    localparam int IMG_HEIGHT = 256;
    localparam int IMG_PIXELS = IMG_WIDTH * IMG_HEIGHT;

    localparam logic [1:0] MORPH_PASS   = 2'd0;
    localparam logic [1:0] MORPH_ERODE  = 2'd1;
    localparam logic [1:0] MORPH_DILATE = 2'd2;
    localparam logic [1:0] MORPH_MAJ    = 2'd3;

    localparam int MORPH_LAT   = IMG_WIDTH + 2;
    localparam int MORPH_FLUSH = IMG_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } morph_state_e;

    // win[4] is the centre; the other eight bits are already border-masked.
    function automatic logic morph_apply(input logic [1:0] m, input logic [8:0] win);
        logic [3:0] cnt;
        cnt = 4'($countones(win));
        case (m)
            MORPH_ERODE:  return &win;
            MORPH_DILATE: return |win;
            MORPH_MAJ:    return (cnt >= 4'd5);
            default:      return win[4];
        endcase
    endfunction
endpackage

// File: rtl/morph_window3x3.sv
// Two line buffers plus a 3x3 shift window over the raster stream; neighbours that
// fall outside the image are replaced by the padding value using the centre counters.
module morph_window3x3
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int ROW_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             centre_en,
    input  logic             pad,
    input  logic             sample_in,
    output logic [8:0]       win,
    output logic [15:0]      centre_line,
    output logic [ROW_W-1:0] centre_row
);
    logic             lb0_mem [WIDTH];
    logic             lb1_mem [WIDTH];
    logic [ROW_W-1:0] wr_idx_q, wr_idx_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [15:0]      line_q, line_d;
    logic [2:0]       col1_q, col1_d, col2_q, col2_d;
    logic [2:0]       col_new;
    logic [8:0]       raw, oob;
    logic             top_oob, bot_oob, left_oob, right_oob;

    // Newest column: bit 0 is two lines up, bit 2 is the sample arriving this cycle.
    assign col_new = {sample_in, lb0_mem[wr_idx_q], lb1_mem[wr_idx_q]};

    always_ff @(posedge clk) begin
        if (shift) begin
            lb0_mem[wr_idx_q] <= sample_in;
            lb1_mem[wr_idx_q] <= lb0_mem[wr_idx_q];
        end
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        row_d    = row_q;
        line_d   = line_q;
        col1_d   = col1_q;
        col2_d   = col2_q;
        if (clear) begin
            wr_idx_d = '0;
            row_d    = '0;
            line_d   = '0;
        end else if (shift) begin
            wr_idx_d = wr_idx_q + 1'b1;
            col1_d   = col_new;
            col2_d   = col1_q;
            if (centre_en) begin
                if (row_q == '1) begin
                    row_d  = '0;
                    line_d = line_q + 16'd1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            row_q    <= '0;
            line_q   <= '0;
            col1_q   <= '0;
            col2_q   <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            row_q    <= row_d;
            line_q   <= line_d;
            col1_q   <= col1_d;
            col2_q   <= col2_d;
        end
    end

    // Bit index is dy*3+dx with (0,0) top-left; masking never trusts buffer contents.
    always_comb begin
        top_oob   = (line_q == 16'd0);
        bot_oob   = (line_q == 16'(HEIGHT - 1));
        left_oob  = (row_q == '0);
        right_oob = (row_q == '1);
        raw = {col_new[2], col1_q[2], col2_q[2],
               col_new[1], col1_q[1], col2_q[1],
               col_new[0], col1_q[0], col2_q[0]};
        oob = {{3{bot_oob}}, 3'b000, {3{top_oob}}} | {3{right_oob, 1'b0, left_oob}};
        win = (raw & ~oob) | ({9{pad}} & oob);
    end

    assign centre_line = line_q;
    assign centre_row  = row_q;
endmodule

// File: rtl/binary_morph.sv
// Scans the binarized map, filters it through a 3x3 erode/dilate/majority/pass kernel
// and streams one result pixel per cycle in raster order.
module binary_morph
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic        morph_clk,
    input  logic        morph_rst_n,
    input  logic        morph_ctrl,
    input  logic [1:0]  mode,
    output logic [15:0] pixel_address,
    input  logic        bin_data,
    output logic        out_valid,
    output logic        out_data,
    output logic [15:0] out_address,
    output logic        done,
    output logic [1:0]  condition_led
);
    localparam int          ROW_W       = $clog2(WIDTH);
    localparam int          PIXELS      = WIDTH * HEIGHT;
    localparam int          FLUSH_LEN   = WIDTH + 1;
    localparam logic [16:0] K_LAST_SCAN = 17'(PIXELS - 1);
    localparam logic [16:0] K_FIRST_CTR = 17'(WIDTH + 1);
    localparam logic [16:0] K_LAST_CTR  = 17'(PIXELS + WIDTH);
    localparam logic [16:0] K_FLUSH_END = 17'(PIXELS + FLUSH_LEN);

    morph_state_e     state_q, state_d;
    logic [16:0]      k_q, k_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_latched_q, done_latched_d;
    logic             out_valid_q, out_valid_d;
    logic             out_data_q, out_data_d;
    logic [15:0]      out_address_q, out_address_d;
    logic             done_q, done_d;
    logic             busy, clear, centre_en, sample, pad;
    logic [8:0]       win;
    logic [15:0]      ctr_line;
    logic [ROW_W-1:0] ctr_row;

    morph_window3x3 #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ROW_W  (ROW_W)
    ) u_window (
        .clk         (morph_clk),
        .rst_n       (morph_rst_n),
        .clear       (clear),
        .shift       (busy),
        .centre_en   (centre_en),
        .pad         (pad),
        .sample_in   (sample),
        .win         (win),
        .centre_line (ctr_line),
        .centre_row  (ctr_row)
    );

    // The flush runs one cycle past the last complete centre so its output register drains before DONE.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        mode_d         = mode_q;
        done_latched_d = done_latched_q;
        clear          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (morph_ctrl) begin
                    state_d        = ST_SCAN;
                    k_d            = '0;
                    mode_d         = mode;
                    done_latched_d = 1'b0;
                    clear          = 1'b1;
                end
            end
            ST_SCAN: begin
                k_d = k_q + 17'd1;
                if (k_q == K_LAST_SCAN) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                k_d = k_q + 17'd1;
                if (k_q == K_FLUSH_END) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
        if (done_d) done_latched_d = 1'b1;
    end

    always_comb begin
        busy          = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
        sample        = (state_q == ST_SCAN) && bin_data;
        pad           = (mode_q == MORPH_ERODE);
        centre_en     = busy && (k_q >= K_FIRST_CTR) && (k_q <= K_LAST_CTR);
        out_valid_d   = centre_en;
        out_data_d    = centre_en && morph_apply(mode_q, win);
        out_address_d = centre_en ? 16'((32'(ctr_line) << ROW_W) | 32'(ctr_row)) : 16'd0;
    end

    always_ff @(posedge morph_clk or negedge morph_rst_n) begin
        if (!morph_rst_n) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            mode_q         <= MORPH_PASS;
            done_latched_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 1'b0;
            out_address_q  <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            mode_q         <= mode_d;
            done_latched_q <= done_latched_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_address_q  <= out_address_d;
            done_q         <= done_d;
        end
    end

    assign pixel_address = (k_q < 17'(PIXELS)) ? k_q[15:0] : 16'(PIXELS - 1);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_address   = out_address_q;
    assign done          = done_q;
    assign condition_led = {done_latched_q, busy};
endmodule

// File: tb/tb_binary_morph.sv
// Bench for binary_morph: a 16x16 instance for the filter functions and a full 256x256
// instance for frame-level timing, both checked every cycle against a neighbourhood model.
module tb_binary_morph;
    import img_pkg::*;

    localparam int W     = 16;
    localparam int H     = 16;
    localparam int N     = W * H;
    localparam int LOG_N = $clog2(N);
    localparam int LAT   = W + 2;
    localparam int END_S = N + W + 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s, ctrl_s, bin_s, ov_s, od_s, done_s;
    logic [1:0]  mode_s, led_s;
    logic [15:0] pix_s, oa_s;
    logic        rst_n_f, ctrl_f, bin_f, ov_f, od_f, done_f;
    logic [1:0]  mode_f, led_f;
    logic [15:0] pix_f, oa_f;

    logic map_s [N];
    logic res_s [N];
    logic map_f [65536];

    assign bin_s = map_s[pix_s[LOG_N-1:0]];
    assign bin_f = map_f[pix_f];

    binary_morph #(.WIDTH(W), .HEIGHT(H)) dut (
        .morph_clk(clk), .morph_rst_n(rst_n_s), .morph_ctrl(ctrl_s), .mode(mode_s),
        .pixel_address(pix_s), .bin_data(bin_s), .out_valid(ov_s), .out_data(od_s),
        .out_address(oa_s), .done(done_s), .condition_led(led_s)
    );

    binary_morph dut_full (
        .morph_clk(clk), .morph_rst_n(rst_n_f), .morph_ctrl(ctrl_f), .mode(mode_f),
        .pixel_address(pix_f), .bin_data(bin_f), .out_valid(ov_f), .out_data(od_f),
        .out_address(oa_f), .done(done_f), .condition_led(led_f)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc_s = 0;
    int         cyc_f = 0;
    bit         run_s = 1'b0;
    bit         run_f = 1'b0;
    logic [1:0] cur_mode = 2'd0;

    task automatic checkOutput(input string name, input int cyc, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference: evaluate the 3x3 neighbourhood of pixel p directly on the 2-D map.
    function automatic logic model_pixel(input int p, input logic [1:0] m);
        int   l, r, ones;
        logic v;
        l = p / W;
        r = p % W;
        ones = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (l + dy < 0 || l + dy >= H || r + dx < 0 || r + dx >= W) v = (m == MORPH_ERODE);
                else v = map_s[(l + dy) * W + r + dx];
                ones += int'(v);
            end
        end
        case (m)
            MORPH_PASS:   return map_s[p];
            MORPH_ERODE:  return ones == 9;
            MORPH_DILATE: return ones > 0;
            default:      return ones >= 5;
        endcase
    endfunction

    function automatic int countRes();
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(res_s[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (run_s) begin
            bit ev;
            ev = (cyc_s >= LAT) && (cyc_s < LAT + N);
            checkOutput("out_valid", cyc_s, ov_s, ev);
            if (ev) begin
                checkOutput("out_address", cyc_s, oa_s, cyc_s - LAT);
                checkOutput("out_data", cyc_s, od_s, model_pixel(cyc_s - LAT, cur_mode));
                if (ov_s === 1'b1) res_s[oa_s[LOG_N-1:0]] = od_s;
            end
            checkOutput("done", cyc_s, done_s, cyc_s == N + W + 2);
            if (cyc_s <= N + W + 1)
                checkOutput("pixel_address", cyc_s, pix_s, (cyc_s < N) ? cyc_s : N - 1);
            checkOutput("busy_led", cyc_s, led_s[0], cyc_s <= N + W + 1);
            if (cyc_s != N + W + 2)
                checkOutput("done_led", cyc_s, led_s[1], cyc_s > N + W + 2);
            cyc_s++;
        end
        if (run_f) begin
            bit ev;
            ev = (cyc_f >= 258) && (cyc_f <= 65793);
            checkOutput("full_out_valid", cyc_f, ov_f, ev);
            if (ev) begin
                checkOutput("full_out_address", cyc_f, oa_f, cyc_f - 258);
                checkOutput("full_out_data", cyc_f, od_f, map_f[cyc_f - 258]);
            end
            checkOutput("full_done", cyc_f, done_f, cyc_f == 65794);
            if (cyc_f <= 65793)
                checkOutput("full_pixel_address", cyc_f, pix_f, (cyc_f < 65536) ? cyc_f : 65535);
            checkOutput("full_busy_led", cyc_f, led_f[0], cyc_f <= 65793);
            cyc_f++;
        end
    end

    task automatic applyStimulus(input logic [1:0] m);
        for (int i = 0; i < N; i++) res_s[i] = 1'b0;
        @(negedge clk);
        mode_s   = m;
        ctrl_s   = 1'b1;
        cur_mode = m;
        @(posedge clk);
        #1;
        ctrl_s = 1'b0;
        mode_s = m ^ 2'b11;
        cyc_s  = 0;
        run_s  = 1'b1;
    endtask

    task automatic runSmallFrame(input logic [1:0] m);
        applyStimulus(m);
        wait (cyc_s == END_S);
        run_s = 1'b0;
    endtask

    task automatic setMap(input logic v);
        for (int i = 0; i < N; i++) map_s[i] = v;
    endtask

    task automatic randMap();
        for (int i = 0; i < N; i++) map_s[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pixel_address"}, 0, pix_s, 0);
        checkOutput({tag, "_out_valid"}, 0, ov_s, 0);
        checkOutput({tag, "_out_data"}, 0, od_s, 0);
        checkOutput({tag, "_out_address"}, 0, oa_s, 0);
        checkOutput({tag, "_done"}, 0, done_s, 0);
        checkOutput({tag, "_condition_led"}, 0, led_s, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog cycle=0 got=1 expected=0");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mism;
        rst_n_s = 1'b0; rst_n_f = 1'b0;
        ctrl_s  = 1'b0; ctrl_f  = 1'b0;
        mode_s  = 2'd0; mode_f  = 2'd0;
        setMap(1'b0);
        for (int i = 0; i < 65536; i++) map_f[i] = 1'($urandom_range(0, 1));
        #12;
        checkResetState("reset");
        checkOutput("reset_full_out_valid", 0, ov_f, 0);
        checkOutput("reset_full_condition_led", 0, led_f, 0);
        @(negedge clk);
        rst_n_s = 1'b1; rst_n_f = 1'b1;

        $display("[TB] dilate, single one at line 5 row 5");
        setMap(1'b0); map_s[5 * W + 5] = 1'b1;
        runSmallFrame(MORPH_DILATE);
        checkOutput("dilate_single_ones", 0, countRes(), 9);
        checkOutput("dilate_single_4_4", 0, res_s[4 * W + 4], 1);
        checkOutput("dilate_single_6_6", 0, res_s[6 * W + 6], 1);
        checkOutput("dilate_single_3_5", 0, res_s[3 * W + 5], 0);

        $display("[TB] dilate, single one at corner");
        setMap(1'b0); map_s[0] = 1'b1;
        runSmallFrame(MORPH_DILATE);
        checkOutput("dilate_corner_ones", 0, countRes(), 4);
        checkOutput("dilate_corner_17", 0, res_s[W + 1], 1);
        checkOutput("dilate_corner_wrap", 0, res_s[W - 1], 0);

        $display("[TB] all ones, erode and majority");
        setMap(1'b1);
        runSmallFrame(MORPH_ERODE);
        checkOutput("erode_all_ones", 0, countRes(), N);
        runSmallFrame(MORPH_MAJ);
        checkOutput("maj_all_ones", 0, countRes(), N - 4);
        checkOutput("maj_corner", 0, res_s[0], 0);
        checkOutput("maj_edge", 0, res_s[1], 1);
        checkOutput("maj_far_corner", 0, res_s[N - 1], 0);

        $display("[TB] majority, isolated one and 2x3 block");
        setMap(1'b0); map_s[8 * W + 8] = 1'b1;
        runSmallFrame(MORPH_MAJ);
        checkOutput("maj_isolated_ones", 0, countRes(), 0);
        setMap(1'b0);
        for (int l = 5; l <= 6; l++)
            for (int r = 5; r <= 7; r++) map_s[l * W + r] = 1'b1;
        runSmallFrame(MORPH_MAJ);
        checkOutput("maj_block_ones", 0, countRes(), 2);
        checkOutput("maj_block_5_6", 0, res_s[5 * W + 6], 1);
        checkOutput("maj_block_6_6", 0, res_s[6 * W + 6], 1);

        $display("[TB] random maps, all modes");
        randMap();
        runSmallFrame(MORPH_PASS);
        mism = 0;
        for (int i = 0; i < N; i++) mism += int'(res_s[i] != map_s[i]);
        checkOutput("pass_bit_exact", 0, mism, 0);
        randMap();
        runSmallFrame(MORPH_ERODE);
        randMap();
        runSmallFrame(MORPH_MAJ);

        $display("[TB] reset mid-scan, then restart with stray start pulses");
        randMap();
        applyStimulus(MORPH_MAJ);
        wait (cyc_s == 100);
        run_s   = 1'b0;
        rst_n_s = 1'b0;
        #1;
        checkResetState("midscan_reset");
        @(negedge clk);
        rst_n_s = 1'b1;
        applyStimulus(MORPH_DILATE);
        wait (cyc_s == 50);
        ctrl_s = 1'b1;
        @(posedge clk); #1 ctrl_s = 1'b0;
        wait (cyc_s == 120);
        mode_s = MORPH_ERODE;
        ctrl_s = 1'b1;
        @(posedge clk); #1 ctrl_s = 1'b0;
        wait (cyc_s == N + W + 3);
        ctrl_s = 1'b1;
        @(posedge clk); #1 ctrl_s = 1'b0;
        wait (cyc_s == END_S);
        run_s = 1'b0;

        $display("[TB] full 256x256 pass frame");
        @(negedge clk);
        mode_f = MORPH_PASS;
        ctrl_f = 1'b1;
        @(posedge clk);
        #1;
        ctrl_f = 1'b0;
        mode_f = MORPH_MAJ;
        cyc_f  = 0;
        run_f  = 1'b1;
        wait (cyc_f == 65796);
        run_f = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
